// File: rtl/iomem_wb8_bridge.sv
// iomem_wb8_bridge: maps a 256-word iomem window onto the 8-bit Wishbone
// slave port of the MachXO2 EFB. Each claimed access becomes one Wishbone
// classic cycle. A down-counter bounds the wait for wb_ack_i, and a sticky
// flag records any timeout.
module iomem_wb8_bridge #(
   parameter logic [31:0] ADDR_BASE = 32'h0300_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_FC00,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [7:0]  wb_adr_o,
   output logic [7:0]  wb_dat_o,
   input  logic [7:0]  wb_dat_i,
   input  logic        wb_ack_i,
   output logic        wb_timeout
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        cyc_q, cyc_d;
   logic        we_q, we_d;
   logic [7:0]  adr_q, adr_d;
   logic [7:0]  dat_q, dat_d;
   logic [31:0] rdata_q, rdata_d;
   logic        ready_q, ready_d;
   logic        timeout_q, timeout_d;

   logic        hit;
   logic        unused_wdata_hi;

   assign hit             = ((iomem_addr & ADDR_MASK) == ADDR_BASE);
   // The EFB registers are 8 bits wide; the upper write lanes carry nothing.
   assign unused_wdata_hi = ^iomem_wdata[31:8];

   // Next-state and registered-output logic of the access FSM.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rdata_d   = rdata_q;
      ready_d   = 1'b0;
      timeout_d = timeout_q;

      case (state_q)
         IDLE: begin
            if (iomem_valid && hit) begin
               if ((iomem_wstrb == 4'b0000) || iomem_wstrb[0]) begin
                  adr_d   = iomem_addr[9:2];
                  we_d    = iomem_wstrb[0];
                  if (iomem_wstrb[0]) begin
                     dat_d = iomem_wdata[7:0];
                  end
                  cyc_d   = 1'b1;
                  cnt_d   = TIMEOUT_C;
                  state_d = BUS;
               end else begin
                  // Only upper lanes written: nothing reaches the EFB.
                  rdata_d = 32'h0000_0000;
                  ready_d = 1'b1;
                  state_d = DONE;
               end
            end
         end

         BUS: begin
            // Ack takes priority over an expiring counter.
            if (wb_ack_i) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               rdata_d = we_q ? 32'h0000_0000 : {24'h00_0000, wb_dat_i};
               ready_d = 1'b1;
               state_d = DONE;
            end else if (cnt_q == 8'd0) begin
               cyc_d     = 1'b0;
               we_d      = 1'b0;
               rdata_d   = 32'hFFFF_FFFF;
               timeout_d = 1'b1;
               ready_d   = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 8'd0;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= 8'd0;
         dat_q     <= 8'd0;
         rdata_q   <= 32'h0000_0000;
         ready_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rdata_q   <= rdata_d;
         ready_q   <= ready_d;
         timeout_q <= timeout_d;
      end
   end

   assign iomem_ready = ready_q;
   assign iomem_rdata = rdata_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = cyc_q;
   assign wb_we_o     = we_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign wb_timeout  = timeout_q;

endmodule

// File: tb/tb_iomem_wb8_bridge.sv
// Self-checking bench for iomem_wb8_bridge (TIMEOUT = 4): table of directed
// accesses plus hand-written timeout, spurious-ack and reset-abort sequences.
module tb_iomem_wb8_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [31:0] iomem_rdata;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [7:0]  wb_adr_o, wb_dat_o;
   logic [7:0]  wb_dat_i;
   logic        wb_ack_i;
   logic        wb_timeout;

   always #5 clk = ~clk;

   iomem_wb8_bridge #(
      .ADDR_BASE(32'h0300_0000),
      .ADDR_MASK(32'hFFFF_FC00),
      .TIMEOUT  (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .iomem_valid(iomem_valid),
      .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb),
      .iomem_addr (iomem_addr),
      .iomem_wdata(iomem_wdata),
      .iomem_rdata(iomem_rdata),
      .wb_cyc_o   (wb_cyc_o),
      .wb_stb_o   (wb_stb_o),
      .wb_we_o    (wb_we_o),
      .wb_adr_o   (wb_adr_o),
      .wb_dat_o   (wb_dat_o),
      .wb_dat_i   (wb_dat_i),
      .wb_ack_i   (wb_ack_i),
      .wb_timeout (wb_timeout)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, want);
      end
   endtask

   typedef struct {
      int          cyc_cnt;
      int          rdy_cnt;
      int          rdy_at;
      logic [31:0] rdata;
      logic [7:0]  adr;
      logic [7:0]  dat;
      logic        we;
      logic        we_at_rdy;
      bit          unstable;
      bit          overlap;
      bit          stb_mismatch;
   } res_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      int          lat;
      logic [7:0]  ack_dat;
      int          exp_cyc;
      int          exp_rdy;
      int          exp_rdy_at;
      logic        exp_we;
      logic [7:0]  exp_adr;
      logic [7:0]  exp_dat;
      logic [31:0] exp_rdata;
      int          cycles;
   } vec_t;

   // Issue one iomem access and act as the Wishbone slave: ack on the
   // lat-th cycle of cyc (lat = 0 never acks). Observes a fixed window.
   task automatic run_access(input logic [31:0] a, input logic [3:0] s,
                             input logic [31:0] wd, input int lat,
                             input logic [7:0] ad, input int cycles,
                             output res_t r);
      r = '{default: 0};
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wstrb = s;
      iomem_wdata = wd;
      for (int c = 1; c <= cycles; c++) begin
         @(negedge clk);
         if (wb_cyc_o !== wb_stb_o) r.stb_mismatch = 1;
         if (iomem_ready === 1'b1) begin
            r.rdy_cnt++;
            if (r.rdy_at == 0) r.rdy_at = c;
            r.rdata     = iomem_rdata;
            r.we_at_rdy = wb_we_o;
            if (wb_cyc_o !== 1'b0) r.overlap = 1;
            iomem_valid = 1'b0;
            iomem_wstrb = 4'b0000;
         end
         if (wb_cyc_o === 1'b1) begin
            r.cyc_cnt++;
            if (r.cyc_cnt == 1) begin
               r.adr = wb_adr_o;
               r.we  = wb_we_o;
               r.dat = wb_dat_o;
            end else if (wb_adr_o !== r.adr || wb_we_o !== r.we || wb_dat_o !== r.dat) begin
               r.unstable = 1;
            end
         end
         wb_ack_i = (wb_cyc_o === 1'b1) && (lat != 0) && (r.cyc_cnt == lat);
         wb_dat_i = wb_ack_i ? ad : ~ad;
      end
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      wb_ack_i    = 1'b0;
   endtask

   vec_t        vecs[9];
   res_t        r;
   logic [31:0] last_rdata;
   int          rdy_seen;

   initial begin
      vecs[0] = '{32'h0300_0028, 4'b0000, 32'h0000_0000, 2, 8'h5A, 2, 1, 3, 1'b0, 8'h0A, 8'h00, 32'h0000_005A, 12};
      vecs[1] = '{32'h0300_0004, 4'b0001, 32'h1234_56C3, 1, 8'h99, 1, 1, 2, 1'b1, 8'h01, 8'hC3, 32'h0000_0000, 12};
      vecs[2] = '{32'h0300_0010, 4'b1100, 32'hDEAD_BEEF, 1, 8'h11, 0, 1, 1, 1'b0, 8'h00, 8'h00, 32'h0000_0000, 12};
      vecs[3] = '{32'h0300_03FC, 4'b0000, 32'h0000_0000, 1, 8'hA5, 1, 1, 2, 1'b0, 8'hFF, 8'h00, 32'h0000_00A5, 12};
      vecs[4] = '{32'h0200_0000, 4'b0000, 32'h0000_0000, 1, 8'h22, 0, 0, 0, 1'b0, 8'h00, 8'h00, 32'h0000_0000, 300};
      vecs[5] = '{32'h0300_0400, 4'b0001, 32'h0000_0055, 1, 8'h33, 0, 0, 0, 1'b0, 8'h00, 8'h00, 32'h0000_0000, 20};
      vecs[6] = '{32'h0300_0008, 4'b0110, 32'h0000_7700, 1, 8'h44, 0, 1, 1, 1'b0, 8'h00, 8'h00, 32'h0000_0000, 12};
      vecs[7] = '{32'h0300_0000, 4'b0000, 32'h0000_0000, 5, 8'h3C, 5, 1, 6, 1'b0, 8'h00, 8'h00, 32'h0000_003C, 12};
      vecs[8] = '{32'h0300_0200, 4'b1111, 32'hFFFF_FF81, 3, 8'h66, 3, 1, 4, 1'b1, 8'h80, 8'h81, 32'h0000_0000, 12};

      reset       = 1'b1;
      iomem_valid = 1'b0;
      iomem_wstrb = 4'b0000;
      iomem_addr  = 32'h0;
      iomem_wdata = 32'h0;
      wb_dat_i    = 8'h00;
      wb_ack_i    = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset ready",   {31'h0, iomem_ready}, 32'h0);
      chk("reset rdata",   iomem_rdata, 32'h0);
      chk("reset cyc",     {31'h0, wb_cyc_o}, 32'h0);
      chk("reset stb",     {31'h0, wb_stb_o}, 32'h0);
      chk("reset we",      {31'h0, wb_we_o}, 32'h0);
      chk("reset adr",     {24'h0, wb_adr_o}, 32'h0);
      chk("reset dat",     {24'h0, wb_dat_o}, 32'h0);
      chk("reset timeout", {31'h0, wb_timeout}, 32'h0);
      reset = 1'b0;
      last_rdata = 32'h0;

      for (int i = 0; i < 9; i++) begin
         run_access(vecs[i].addr, vecs[i].strb, vecs[i].wdata, vecs[i].lat,
                    vecs[i].ack_dat, vecs[i].cycles, r);
         chk($sformatf("v%0d cyc cycles", i), r.cyc_cnt, vecs[i].exp_cyc);
         chk($sformatf("v%0d ready pulses", i), r.rdy_cnt, vecs[i].exp_rdy);
         chk($sformatf("v%0d ready latency", i), r.rdy_at, vecs[i].exp_rdy_at);
         chk($sformatf("v%0d cyc/stb equal", i), {31'h0, r.stb_mismatch}, 32'h0);
         chk($sformatf("v%0d bus stable", i), {31'h0, r.unstable}, 32'h0);
         if (vecs[i].exp_rdy != 0) begin
            chk($sformatf("v%0d rdata", i), r.rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d cyc low with ready", i), {31'h0, r.overlap}, 32'h0);
            chk($sformatf("v%0d we low with ready", i), {31'h0, r.we_at_rdy}, 32'h0);
            last_rdata = vecs[i].exp_rdata;
         end
         chk($sformatf("v%0d rdata held", i), iomem_rdata, last_rdata);
         if (vecs[i].exp_cyc != 0) begin
            chk($sformatf("v%0d adr", i), {24'h0, r.adr}, {24'h0, vecs[i].exp_adr});
            chk($sformatf("v%0d we", i), {31'h0, r.we}, {31'h0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
               chk($sformatf("v%0d wdat", i), {24'h0, r.dat}, {24'h0, vecs[i].exp_dat});
            end
         end
         chk($sformatf("v%0d timeout flag", i), {31'h0, wb_timeout}, 32'h0);
      end

      // Spurious ack while idle must not produce a response.
      rdy_seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (iomem_ready === 1'b1 || wb_cyc_o === 1'b1) rdy_seen++;
         wb_ack_i = (c < 3);
         wb_dat_i = 8'hEE;
      end
      wb_ack_i = 1'b0;
      chk("spurious ack ignored", rdy_seen, 0);
      chk("spurious ack rdata", iomem_rdata, last_rdata);

      // Timeout: no ack, cyc held TIMEOUT+1 cycles.
      run_access(32'h0300_0008, 4'b0000, 32'h0, 0, 8'h00, 12, r);
      chk("timeout cyc cycles", r.cyc_cnt, 5);
      chk("timeout ready pulses", r.rdy_cnt, 1);
      chk("timeout ready latency", r.rdy_at, 6);
      chk("timeout rdata", r.rdata, 32'hFFFF_FFFF);
      chk("timeout cyc low with ready", {31'h0, r.overlap}, 32'h0);
      chk("timeout flag set", {31'h0, wb_timeout}, 32'h1);

      // Flag is sticky across a normal access.
      run_access(32'h0300_000C, 4'b0000, 32'h0, 1, 8'h77, 12, r);
      chk("after-timeout rdata", r.rdata, 32'h0000_0077);
      chk("after-timeout ready latency", r.rdy_at, 2);
      chk("timeout flag sticky", {31'h0, wb_timeout}, 32'h1);

      // Reset while a bus cycle is outstanding.
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = 32'h0300_0014;
      iomem_wstrb = 4'b0000;
      @(negedge clk);
      iomem_valid = 1'b0;
      chk("abort cyc up", {31'h0, wb_cyc_o}, 32'h1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort cyc dropped", {31'h0, wb_cyc_o}, 32'h0);
      chk("abort stb dropped", {31'h0, wb_stb_o}, 32'h0);
      chk("abort rdata reset", iomem_rdata, 32'h0);
      chk("abort adr reset", {24'h0, wb_adr_o}, 32'h0);
      chk("timeout cleared", {31'h0, wb_timeout}, 32'h0);
      reset = 1'b0;
      rdy_seen = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (iomem_ready === 1'b1) rdy_seen++;
      end
      chk("abort no ready", rdy_seen, 0);
      chk("abort cyc stays low", {31'h0, wb_cyc_o}, 32'h0);

      run_access(32'h0300_0028, 4'b0000, 32'h0, 1, 8'hC7, 12, r);
      chk("post-reset read rdata", r.rdata, 32'h0000_00C7);
      chk("post-reset read ready", r.rdy_cnt, 1);
      chk("post-reset read adr", {24'h0, r.adr}, 32'h0000_000A);
      chk("post-reset timeout", {31'h0, wb_timeout}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iomem_wb8_bridge.md
# iomem_wb8_bridge

Bridges the femtosoc `iomem` bus to the 8-bit Wishbone slave port of the MachXO2 EFB (hard I2C/SPI/timer block), downstream of the SoC core next to the LED register. Each 32-bit word in a decoded window maps to one 8-bit EFB register. The bridge converts each `iomem` access into one Wishbone classic cycle. A timeout guards against a missing `wb_ack_i`.

## Interface
- `ADDR_BASE`, default 32'h0300_0000: base of the decoded window.
- `ADDR_MASK`, default 32'hFFFF_FC00: the bridge claims an access when `(iomem_addr & ADDR_MASK) == ADDR_BASE`, giving 256 words.
- `TIMEOUT`, default 255: maximum cycles to wait for `wb_ack_i`, range 1..255.
- `clk`  in  1: single clock, shared with the SoC and the EFB `wb_clk_i`.
- `reset`  in  1: synchronous, active-high reset.
- `iomem_valid`  in  1: access request from the SoC.
- `iomem_ready`  out  1: one-cycle completion pulse for a claimed access.
- `iomem_wstrb`  in  4: byte write strobes; 0 means read.
- `iomem_addr`  in  32: byte address.
- `iomem_wdata`  in  32: write data; only `[7:0]` is used.
- `iomem_rdata`  out  32: read data, valid while `iomem_ready` is 1.
- `wb_cyc_o`, `wb_stb_o`  out  1 each: Wishbone cycle and strobe, always driven equal.
- `wb_we_o`  out  1: Wishbone write enable.
- `wb_adr_o`  out  8: EFB register address, equal to `iomem_addr[9:2]`.
- `wb_dat_o`  out  8: Wishbone write data.
- `wb_dat_i`  in  8: Wishbone read data.
- `wb_ack_i`  in  1: Wishbone acknowledge.
- `wb_timeout`  out  1: sticky flag, set on any timeout, cleared only by `reset`.

## Operation
- All outputs are registered.
- Reset values:
  - `iomem_ready`=0, `iomem_rdata`=0.
  - `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0.
  - `wb_timeout`=0, state=IDLE, timeout counter=0.
- FSM states: IDLE, BUS, DONE.
- IDLE:
  - Ignores `iomem_valid` when the address is outside the window. Another slave responds; the bridge never asserts `iomem_ready` for it.
  - Claimed access with `wstrb`==0 (read): latch `wb_adr_o`=`addr[9:2]`, `wb_we_o`=0, assert cyc/stb, load counter, go to BUS.
  - Claimed access with `wstrb[0]`=1 (write): same as a read, but `wb_we_o`=1 and `wb_dat_o`=`wdata[7:0]`.
  - Claimed access with `wstrb`!=0 and `wstrb[0]`=0: no Wishbone cycle; go to DONE with `iomem_rdata`=0. Upper-lane writes are discarded.
- BUS: cyc/stb and address/data/we are held stable until ack or timeout.
  - `wb_ack_i`=1: drop cyc/stb/we; latch `iomem_rdata`={24'h0, `wb_dat_i`} (written as 0 for writes); go to DONE.
  - Counter reaches 0 without ack: drop cyc/stb/we; `iomem_rdata`=32'hFFFF_FFFF; set `wb_timeout`; go to DONE.
  - Otherwise decrement the counter.
  - Ack on the same cycle the counter hits 0: ack wins, no timeout.
- DONE: `iomem_ready`=1 for exactly this cycle, then go to IDLE. `iomem_rdata` holds its value until the next access completes.
- Only one Wishbone cycle is outstanding at a time. Changes to `iomem_*` inputs while in BUS or DONE are ignored.
- `wb_ack_i` seen in IDLE or DONE (spurious) is ignored.
- `reset` asserted in any state: everything returns to reset values on the next edge; cyc/stb drop immediately at that edge. The aborted access never gets `iomem_ready`.

## Timing
- Claimed `iomem_valid` sampled at edge N → cyc/stb high from N+1.
- Ack sampled at edge M → cyc/stb low and `iomem_ready` high from M+1; the SoC samples ready at edge M+2.
- Zero-wait slave (ack sampled at N+1): ready high during cycle N+2..N+3, so access latency is 2 cycles after valid.
- No-bus-cycle write: ready high during cycle N+1..N+2.
- Timeout: with no ack, cyc/stb stay high for TIMEOUT+1 cycles, then ready follows one cycle later.
- Back-to-back: a new valid may be accepted on the first cycle after DONE.
- Throughput: at most one access per 3 cycles.

## Test plan
- **Read:** reset, then read 0x0300_0028 with the BFM acking 2 cycles after stb with `wb_dat_i`=8'h5A → `wb_adr_o`=8'h0A, `wb_we_o`=0, `iomem_rdata`=32'h0000_005A, `iomem_ready` high exactly 1 cycle, cyc/stb low in the same cycle as ready.
- **Write, lane 0:** write 0x0300_0004 with `wdata`=32'h1234_56C3, `wstrb`=4'b0001 → one cycle with `wb_adr_o`=8'h01, `wb_dat_o`=8'hC3, `wb_we_o`=1; ready 1 cycle after ack.
- **Write, upper lanes only:** `wstrb`=4'b1100 → cyc never asserted; `iomem_ready` high the cycle after valid; `iomem_rdata`=0.
- **Out-of-window:** access to 0x0200_0000 → no cyc, no ready for 300 cycles.
- **Timeout:** `TIMEOUT`=4, read with no ack → cyc/stb high for 5 cycles; `iomem_rdata`=32'hFFFF_FFFF; `wb_timeout`=1 and stays 1 across the next, normally acked, access; it clears only after `reset`.
- **Reset mid-access:** `reset` asserted while in BUS → cyc/stb 0 at the next edge, no ready pulse. A read issued after `reset` releases completes normally.
